// File: rtl/sb_pkg.sv
// Shared types and constants for the dual-issue register scoreboard.
package sb_pkg;

    localparam int unsigned NREGS = 32;
    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StStall = 2'd2
    } sb_state_e;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
    } sb_entry_t;

    // One-hot register mask; x0 never maps to a bit so it can never be busy.
    function automatic logic [NREGS-1:0] reg_mask(input logic [REG_W-1:0] idx);
        reg_mask = '0;
        if (idx != '0) begin
            reg_mask[idx] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/sb_wb_pipe.sv
// Writeback shift pipeline for one issue slot; the tail stage is the
// register-file write presented to the datapath.
module sb_wb_pipe
    import sb_pkg::*;
#(
    parameter int unsigned WB_LAT = 2
) (
    input  logic      clk,
    input  logic      n_rst,
    input  logic      flush,
    input  sb_entry_t in_entry,
    output sb_entry_t tail
);

    sb_entry_t stage_q [WB_LAT];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stage_q <= '{default: '0};
        end else if (flush) begin
            stage_q <= '{default: '0};
        end else begin
            stage_q[0] <= in_entry;
            for (int unsigned i = 1; i < WB_LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tail = stage_q[WB_LAT-1];

endmodule

// File: rtl/issue_scoreboard.sv
// Dual-slot in-order issue scoreboard with per-slot writeback pipelines.
// Define SB_WB_BYPASS_EN to treat registers being written back this cycle as free.
module issue_scoreboard
    import sb_pkg::*;
#(
    parameter int unsigned WB_LAT = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   ins0_valid,
    input  logic [REG_W-1:0]       ins0_rd,
    input  logic [REG_W-1:0]       ins0_rs1,
    input  logic [REG_W-1:0]       ins0_rs2,
    input  logic                   ins0_wen,
    input  logic                   ins1_valid,
    input  logic [REG_W-1:0]       ins1_rd,
    input  logic [REG_W-1:0]       ins1_rs1,
    input  logic [REG_W-1:0]       ins1_rs2,
    input  logic                   ins1_wen,
    input  logic                   flush,
    output logic                   issue0,
    output logic                   issue1,
    output logic                   wb0_valid,
    output logic                   wb1_valid,
    output logic [REG_W-1:0]       wb0_rd,
    output logic [REG_W-1:0]       wb1_rd,
    output logic [NREGS-1:0]       busy,
    output logic [1:0]             state,
    output logic [CNT_W-1:0]       stall_cnt
);

    logic [NREGS-1:0] busy_q, busy_d, busy_eff;
    logic [NREGS-1:0] wb_mask, set_mask;
    logic [NREGS-1:0] need0, need1;
    logic             pair_hz, stall;
    sb_entry_t        tail0, tail1, in0, in1;
    sb_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign wb_mask = (tail0.valid ? reg_mask(tail0.rd) : '0)
                   | (tail1.valid ? reg_mask(tail1.rd) : '0);

`ifdef SB_WB_BYPASS_EN
    assign busy_eff = busy_q & ~wb_mask;
`else
    assign busy_eff = busy_q;
`endif

    assign need0 = reg_mask(ins0_rs1) | reg_mask(ins0_rs2)
                 | (ins0_wen ? reg_mask(ins0_rd) : '0);
    assign need1 = reg_mask(ins1_rs1) | reg_mask(ins1_rs2)
                 | (ins1_wen ? reg_mask(ins1_rd) : '0);

    // Slot 0 writing a register slot 1 touches forces slot 1 to wait a cycle.
    assign pair_hz = ins0_wen && (ins0_rd != '0)
                   && ((ins0_rd == ins1_rs1) || (ins0_rd == ins1_rs2) || (ins0_rd == ins1_rd));

    assign issue0 = ins0_valid && !flush && ((need0 & busy_eff) == '0);
    assign issue1 = ins1_valid && issue0 && !pair_hz && ((need1 & busy_eff) == '0);

    assign in0 = '{valid: issue0 && ins0_wen && (ins0_rd != '0), rd: ins0_rd};
    assign in1 = '{valid: issue1 && ins1_wen && (ins1_rd != '0), rd: ins1_rd};

    assign set_mask = (in0.valid ? reg_mask(in0.rd) : '0)
                    | (in1.valid ? reg_mask(in1.rd) : '0);

    // Set is applied after clear so a same-cycle reissue keeps the register busy.
    always_comb begin
        busy_d = (busy_q & ~wb_mask) | set_mask;
        if (flush) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    sb_wb_pipe #(.WB_LAT(WB_LAT)) u_pipe0 (
        .clk      (clk),
        .n_rst    (n_rst),
        .flush    (flush),
        .in_entry (in0),
        .tail     (tail0)
    );

    sb_wb_pipe #(.WB_LAT(WB_LAT)) u_pipe1 (
        .clk      (clk),
        .n_rst    (n_rst),
        .flush    (flush),
        .in_entry (in1),
        .tail     (tail1)
    );

    assign stall = ins0_valid && !issue0;

    always_comb begin
        state_d = StIdle;
        if (!ins0_valid) begin
            state_d = StIdle;
        end else if (issue0) begin
            state_d = StRun;
        end else begin
            state_d = StStall;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wb0_valid = tail0.valid;
    assign wb0_rd    = tail0.rd;
    assign wb1_valid = tail1.valid;
    assign wb1_rd    = tail1.rd;
    assign busy      = busy_q;
    assign state     = state_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Scoreboard bench for issue_scoreboard: expected writebacks queue at issue time
// and are retired when the DUT presents them.
module tb_issue_scoreboard;

    localparam int WB_LAT  = 2;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic n_rst;
    logic ins0_valid, ins0_wen, ins1_valid, ins1_wen, flush;
    logic [4:0] ins0_rd, ins0_rs1, ins0_rs2, ins1_rd, ins1_rs1, ins1_rs2;
    logic issue0, issue1, wb0_valid, wb1_valid;
    logic [4:0] wb0_rd, wb1_rd;
    logic [31:0] busy;
    logic [1:0] state;
    logic [CNT_W-1:0] stall_cnt;

    typedef struct {
        logic [4:0] rd;
        int         due;
    } wb_exp_t;

    wb_exp_t q0[$];
    wb_exp_t q1[$];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [31:0] exp_busy = '0;
    int exp_stall = 0;
    int exp_state = 0;

    always #5 clk = ~clk;

    issue_scoreboard #(.WB_LAT(WB_LAT), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .ins0_valid (ins0_valid),
        .ins0_rd    (ins0_rd),
        .ins0_rs1   (ins0_rs1),
        .ins0_rs2   (ins0_rs2),
        .ins0_wen   (ins0_wen),
        .ins1_valid (ins1_valid),
        .ins1_rd    (ins1_rd),
        .ins1_rs1   (ins1_rs1),
        .ins1_rs2   (ins1_rs2),
        .ins1_wen   (ins1_wen),
        .flush      (flush),
        .issue0     (issue0),
        .issue1     (issue1),
        .wb0_valid  (wb0_valid),
        .wb1_valid  (wb1_valid),
        .wb0_rd     (wb0_rd),
        .wb1_rd     (wb1_rd),
        .busy       (busy),
        .state      (state),
        .stall_cnt  (stall_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] bit_of(input logic [4:0] r);
        bit_of = '0;
        if (r != 5'd0) bit_of[r] = 1'b1;
    endfunction

    task automatic set_ins(input logic v0, input logic [4:0] rd0, input logic [4:0] a0,
                           input logic [4:0] b0, input logic w0, input logic v1,
                           input logic [4:0] rd1, input logic [4:0] a1, input logic [4:0] b1,
                           input logic w1);
        ins0_valid = v0; ins0_rd = rd0; ins0_rs1 = a0; ins0_rs2 = b0; ins0_wen = w0;
        ins1_valid = v1; ins1_rd = rd1; ins1_rs1 = a1; ins1_rs2 = b1; ins1_wen = w1;
    endtask

    task automatic set_idle();
        set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic run_cycle(input logic e0, input logic e1);
        wb_exp_t e;
        logic [31:0] clr;
        clr = '0;
        if (q0.size() != 0 && q0[0].due == cyc) begin
            e = q0.pop_front();
            check_val("wb0_valid", wb0_valid, 1);
            check_val("wb0_rd", wb0_rd, e.rd);
            clr |= bit_of(e.rd);
        end else begin
            check_val("wb0_idle", wb0_valid, 0);
        end
        if (q1.size() != 0 && q1[0].due == cyc) begin
            e = q1.pop_front();
            check_val("wb1_valid", wb1_valid, 1);
            check_val("wb1_rd", wb1_rd, e.rd);
            clr |= bit_of(e.rd);
        end else begin
            check_val("wb1_idle", wb1_valid, 0);
        end
        #4;
        check_val("issue0", issue0, e0);
        check_val("issue1", issue1, e1);
        exp_busy = exp_busy & ~clr;
        if (e0 && ins0_wen && ins0_rd != 0) begin
            q0.push_back('{rd: ins0_rd, due: cyc + WB_LAT});
            exp_busy |= bit_of(ins0_rd);
        end
        if (e1 && ins1_wen && ins1_rd != 0) begin
            q1.push_back('{rd: ins1_rd, due: cyc + WB_LAT});
            exp_busy |= bit_of(ins1_rd);
        end
        if (flush) begin
            q0.delete();
            q1.delete();
            exp_busy = '0;
        end
        if (ins0_valid && !e0) exp_stall = (exp_stall == CNT_MAX) ? CNT_MAX : exp_stall + 1;
        exp_state = !ins0_valid ? 0 : (e0 ? 1 : 2);
        @(posedge clk);
        #1;
        cyc++;
        check_val("state", state, exp_state);
        check_val("stall_cnt", stall_cnt, exp_stall);
        check_val("busy", busy, exp_busy);
    endtask

    initial begin
        int stalls;
        n_rst = 1'b0;
        flush = 1'b0;
        set_idle();
        #12;
        check_val("rst_busy", busy, 0);
        check_val("rst_state", state, 0);
        check_val("rst_stall", stall_cnt, 0);
        check_val("rst_wb0", wb0_valid, 0);
        check_val("rst_wb1", wb1_valid, 0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        cyc = 0;

        // Independent dual issue
        set_ins(1, 1, 2, 3, 1, 1, 4, 5, 6, 1);
        run_cycle(1, 1);
        set_idle();
        repeat (3) run_cycle(0, 0);

        // Intra-pair RAW
        set_ins(1, 5, 0, 0, 1, 1, 8, 5, 0, 1);
        run_cycle(1, 0);
        set_idle();
        repeat (3) run_cycle(0, 0);

        // Cross-cycle RAW on x7
        set_ins(1, 7, 0, 0, 1, 0, 0, 0, 0, 0);
        run_cycle(1, 0);
        set_ins(1, 10, 7, 0, 1, 0, 0, 0, 0, 0);
`ifdef SB_WB_BYPASS_EN
        stalls = 1;
`else
        stalls = 2;
`endif
        for (int k = 0; k < stalls; k++) run_cycle(0, 0);
        run_cycle(1, 0);
        set_idle();
        repeat (3) run_cycle(0, 0);

        // x0 immunity
        set_ins(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        run_cycle(1, 0);
        set_ins(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        run_cycle(1, 0);
        set_idle();
        repeat (3) run_cycle(0, 0);

        // Flush with x3 and x9 in flight
        set_ins(1, 3, 0, 0, 1, 1, 9, 0, 0, 1);
        run_cycle(1, 1);
        set_ins(1, 12, 0, 0, 1, 0, 0, 0, 0, 0);
        flush = 1'b1;
        run_cycle(0, 0);
        flush = 1'b0;
        set_idle();
        repeat (3) run_cycle(0, 0);

        // Counter saturation: flushed valid slot-0 cycles count as stalls
        set_ins(1, 12, 0, 0, 1, 0, 0, 0, 0, 0);
        flush = 1'b1;
        repeat (20) run_cycle(0, 0);
        flush = 1'b0;
        set_idle();
        check_val("stall_sat", stall_cnt, CNT_MAX);
        run_cycle(0, 0);

        // Reset while writebacks are in flight
        set_ins(1, 3, 0, 0, 1, 1, 9, 0, 0, 1);
        run_cycle(1, 1);
        set_idle();
        run_cycle(0, 0);
        check_val("wb0_pre_rst", wb0_valid, 1);
        check_val("wb1_pre_rst", wb1_valid, 1);
        #2;
        n_rst = 1'b0;
        #1;
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_wb0", wb0_valid, 0);
        check_val("mid_rst_wb0_rd", wb0_rd, 0);
        check_val("mid_rst_wb1", wb1_valid, 0);
        check_val("mid_rst_state", state, 0);
        check_val("mid_rst_stall", stall_cnt, 0);
        q0.delete();
        q1.delete();
        exp_busy = '0;
        exp_stall = 0;
        exp_state = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (4) run_cycle(0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
